// File: rtl/bidir_bus_pkg.sv
// Shared types and helpers for the half-duplex bus sequencer.
// Holds the state encoding and the down-counter sizing rule.
package bidir_bus_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_e;

    // Counter must hold (N-1) for the longest of the three phase lengths.
    function automatic int cnt_width(input int hold_c, input int sample_c, input int turn_c);
        int m;
        m = (hold_c > sample_c) ? hold_c : sample_c;
        if (turn_c > m) begin
            m = turn_c;
        end else begin
            m = m;
        end
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bidir_bus_ctrl_if.sv
// Host handshake plus pin-cell controls of the bus sequencer.
// The controller uses the slave view; whoever drives it uses master.
interface bidir_bus_ctrl_if
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             oe;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] din;

    modport master (
        output req_valid, req_write, req_data, din,
        input  req_ready, rsp_valid, rsp_data, busy, oe, dout
    );

    modport slave (
        input  req_valid, req_write, req_data, din,
        output req_ready, rsp_valid, rsp_data, busy, oe, dout
    );

endinterface

// File: rtl/bidir_bus_pin.sv
// Behavioural model of the 4-bit bidirectional pad cell.
// Drives the pad only while OE is high; Din always sees the resolved pad.
module bidir_bus_pin #(
    parameter int WIDTH = 4
) (
    input  logic             OE,
    input  logic [WIDTH-1:0] Dout,
    output logic [WIDTH-1:0] Din,
    inout  wire  [WIDTH-1:0] PAD
);

    assign PAD = OE ? Dout : {WIDTH{1'bz}};
    assign Din = PAD;

endmodule

// File: rtl/bidir_bus_port.sv
// Pad-boundary wrapper: sequencer plus bidirectional pin cell on one bus.
module bidir_bus_port
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES  = 2,
    parameter int SAMPLE_DELAY = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [WIDTH-1:0] req_data_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             busy_o,
    inout  wire  [WIDTH-1:0] bus_io
);

    bidir_bus_ctrl_if #(.WIDTH(WIDTH)) bus_int ();

    assign bus_int.req_valid = req_valid_i;
    assign bus_int.req_write = req_write_i;
    assign bus_int.req_data  = req_data_i;
    assign req_ready_o       = bus_int.req_ready;
    assign rsp_valid_o       = bus_int.rsp_valid;
    assign rsp_data_o        = bus_int.rsp_data;
    assign busy_o            = bus_int.busy;

    bidir_bus_ctrl #(
        .WIDTH        (WIDTH),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .SAMPLE_DELAY (SAMPLE_DELAY),
        .TURN_CYCLES  (TURN_CYCLES)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_int)
    );

    bidir_bus_pin #(.WIDTH(WIDTH)) u_pin (
        .OE   (bus_int.oe),
        .Dout (bus_int.dout),
        .Din  (bus_int.din),
        .PAD  (bus_io)
    );

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Initiator-side sequencer for a half-duplex shared bus: drive window for
// writes, release-and-sample window for reads, idle gap after each transfer.
module bidir_bus_ctrl
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES  = 2,
    parameter int SAMPLE_DELAY = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    bidir_bus_ctrl_if.slave bus
);

    localparam int CW = cnt_width(HOLD_CYCLES, SAMPLE_DELAY, TURN_CYCLES);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HOLD_LOAD   = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t SAMPLE_LOAD = cnt_t'(SAMPLE_DELAY - 1);
    localparam cnt_t TURN_LOAD   = cnt_t'(TURN_CYCLES - 1);
    localparam cnt_t CNT_ZERO    = cnt_t'(0);
    localparam cnt_t CNT_ONE     = cnt_t'(1);

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic             oe_q, oe_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Next-state, phase counter and registered pin/response controls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        oe_d        = oe_q;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_write) begin
                        state_d = WRITE;
                        cnt_d   = HOLD_LOAD;
                        oe_d    = 1'b1;
                        dout_d  = bus.req_data;
                    end else begin
                        state_d = READ;
                        cnt_d   = SAMPLE_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = TURN;
                    cnt_d   = TURN_LOAD;
                    oe_d    = 1'b0;
                    dout_d  = {WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            READ: begin
                // din is only ever sampled into a register, never routed out.
                if (cnt_q == CNT_ZERO) begin
                    state_d     = TURN;
                    cnt_d       = TURN_LOAD;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.din;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            TURN: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                oe_d    = 1'b0;
                dout_d  = {WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers; reset releases the bus without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            oe_q        <= 1'b0;
            dout_q      <= {WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.oe        = oe_q;
    assign bus.dout      = dout_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: default timing (dut0) and a 1/1/3 sweep (dut1)
// share one stimulus stream and are checked against a cycle-schedule model.
module tb_bidir_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_write;
    logic [3:0] req_data, din;
    logic       chk_en = 1'b0;

    always #5 clk = ~clk;

    bidir_bus_ctrl_if #(.WIDTH(4)) bus0 ();
    bidir_bus_ctrl_if #(.WIDTH(4)) bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_write = req_write;
    assign bus0.req_data  = req_data;
    assign bus0.din       = din;
    assign bus1.req_valid = req_valid;
    assign bus1.req_write = req_write;
    assign bus1.req_data  = req_data;
    assign bus1.din       = din;

    bidir_bus_ctrl #(.WIDTH(4), .HOLD_CYCLES(2), .SAMPLE_DELAY(2), .TURN_CYCLES(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bidir_bus_ctrl #(.WIDTH(4), .HOLD_CYCLES(1), .SAMPLE_DELAY(1), .TURN_CYCLES(3))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic       oe_a[2], rdy_a[2], busy_a[2], rv_a[2];
    logic [3:0] dout_a[2], rd_a[2];
    assign oe_a[0] = bus0.oe;        assign oe_a[1] = bus1.oe;
    assign rdy_a[0] = bus0.req_ready; assign rdy_a[1] = bus1.req_ready;
    assign busy_a[0] = bus0.busy;    assign busy_a[1] = bus1.busy;
    assign rv_a[0] = bus0.rsp_valid; assign rv_a[1] = bus1.rsp_valid;
    assign dout_a[0] = bus0.dout;    assign dout_a[1] = bus1.dout;
    assign rd_a[0] = bus0.rsp_data;  assign rd_a[1] = bus1.rsp_data;

    int n_chk = 0;
    int n_pass = 0;
    int contention = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    endtask

    function automatic int hold_of(input int d);   return (d == 0) ? 2 : 1; endfunction
    function automatic int samp_of(input int d);   return (d == 0) ? 2 : 1; endfunction
    function automatic int turn_of(input int d);   return (d == 0) ? 1 : 3; endfunction

    // Model: schedule of expected outputs per cycle (ring of 64 cycles).
    // Cycle c is the period following edge c-1; an accept at edge k books cycles k+1...
    int         cyc = 0;
    int         free_cyc[2];
    bit         exp_oe[2][64], exp_rv[2][64], exp_drv[2][64], cap[2][64];
    logic [3:0] exp_dout[2][64];
    logic [3:0] rsp_m[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 64; i++) begin
                    exp_oe[d][i] = 1'b0; exp_rv[d][i] = 1'b0;
                    exp_drv[d][i] = 1'b0; cap[d][i] = 1'b0;
                    exp_dout[d][i] = 4'h0;
                end
                free_cyc[d] = cyc;
                rsp_m[d] = 4'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (cap[d][cyc % 64]) begin
                    rsp_m[d] = din;
                    exp_rv[d][(cyc + 1) % 64] = 1'b1;
                    cap[d][cyc % 64] = 1'b0;
                end
                if (req_valid && cyc >= free_cyc[d]) begin
                    if (req_write) begin
                        for (int j = 1; j <= hold_of(d); j++) begin
                            exp_oe[d][(cyc + j) % 64] = 1'b1;
                            exp_dout[d][(cyc + j) % 64] = req_data;
                        end
                        free_cyc[d] = cyc + 1 + hold_of(d) + turn_of(d);
                    end else begin
                        for (int j = 1; j <= samp_of(d); j++)
                            exp_drv[d][(cyc + j) % 64] = 1'b1;
                        cap[d][(cyc + samp_of(d)) % 64] = 1'b1;
                        free_cyc[d] = cyc + 1 + samp_of(d) + turn_of(d);
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare every cycle against the model, and watch for bus contention.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int d = 0; d < 2; d++) begin
                int s;
                s = cyc % 64;
                chk($sformatf("oe[%0d]", d), 32'(oe_a[d]), 32'(exp_oe[d][s]));
                chk($sformatf("dout[%0d]", d), 32'(dout_a[d]), 32'(exp_dout[d][s]));
                chk($sformatf("rsp_valid[%0d]", d), 32'(rv_a[d]), 32'(exp_rv[d][s]));
                chk($sformatf("rsp_data[%0d]", d), 32'(rd_a[d]), 32'(rsp_m[d]));
                chk($sformatf("req_ready[%0d]", d), 32'(rdy_a[d]), 32'(cyc >= free_cyc[d]));
                chk($sformatf("busy[%0d]", d), 32'(busy_a[d]), 32'(cyc < free_cyc[d]));
                if (exp_drv[d][s] && oe_a[d] === 1'b1) contention++;
                exp_oe[d][s] = 1'b0; exp_rv[d][s] = 1'b0;
                exp_drv[d][s] = 1'b0; exp_dout[d][s] = 4'h0;
            end
        end
    end

    task automatic at_cyc(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("at_cyc", 32'(cyc), 32'(c));
    endtask

    // Present a request to the shared inputs until dut d accepts it; k = accept edge.
    task automatic send(input int d, input logic w, input logic [3:0] dat, output int k);
        k = -1;
        req_valid = 1'b1; req_write = w; req_data = dat;
        for (int n = 0; n < 100; n++) begin
            if (rdy_a[d]) begin
                k = cyc;
                break;
            end
            @(negedge clk);
        end
        if (k < 0) begin
            chk("send_timeout", 32'd0, 32'd1);
            k = cyc;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int k, k2;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_data = 4'h0; din = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(bus0.oe), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus0.rsp_data), 32'd0);
        chk("rst_dout", 32'(bus0.dout), 32'd0);
        @(negedge clk);

        // Single write, default timing.
        send(0, 1'b1, 4'hA, k);
        at_cyc(k + 1); chk("wr_oe1", 32'(bus0.oe), 32'd1); chk("wr_dout1", 32'(bus0.dout), 32'hA);
        at_cyc(k + 2); chk("wr_oe2", 32'(bus0.oe), 32'd1); chk("wr_dout2", 32'(bus0.dout), 32'hA);
        at_cyc(k + 3); chk("wr_oe3", 32'(bus0.oe), 32'd0); chk("wr_dout3", 32'(bus0.dout), 32'h0);
        chk("wr_ready3", 32'(bus0.req_ready), 32'd0);
        at_cyc(k + 4); chk("wr_ready4", 32'(bus0.req_ready), 32'd1);

        // Single read, responder drives 5.
        din = 4'h5;
        send(0, 1'b0, 4'h0, k);
        at_cyc(k + 2); chk("rd_oe2", 32'(bus0.oe), 32'd0); chk("rd_rv2", 32'(bus0.rsp_valid), 32'd0);
        at_cyc(k + 3); chk("rd_rv3", 32'(bus0.rsp_valid), 32'd1); chk("rd_data3", 32'(bus0.rsp_data), 32'h5);
        at_cyc(k + 4); chk("rd_rv4", 32'(bus0.rsp_valid), 32'd0); chk("rd_ready4", 32'(bus0.req_ready), 32'd1);

        // Back-to-back write then read with valid held.
        din = 4'h7;
        send(0, 1'b1, 4'h6, k);
        send(0, 1'b0, 4'h0, k2);
        chk("b2b_accept", 32'(k2), 32'(k + 4));
        at_cyc(k2 + 3); chk("b2b_rd_data", 32'(bus0.rsp_data), 32'h7);

        // Stall: a second write held while busy must not disturb the first.
        at_cyc(k2 + 4);
        send(0, 1'b1, 4'h3, k);
        req_valid = 1'b1; req_write = 1'b1; req_data = 4'hC;
        at_cyc(k + 2); chk("stall_dout", 32'(bus0.dout), 32'h3);
        send(0, 1'b1, 4'hC, k2);
        chk("stall_accept", 32'(k2), 32'(k + 4));
        at_cyc(k2 + 1); chk("stall_dout2", 32'(bus0.dout), 32'hC);

        // Sweep instance: HOLD=1, SAMPLE=1, TURN=3.
        din = 4'hB;
        send(1, 1'b1, 4'h9, k);
        at_cyc(k + 1); chk("sw_oe1", 32'(bus1.oe), 32'd1); chk("sw_dout1", 32'(bus1.dout), 32'h9);
        at_cyc(k + 2); chk("sw_oe2", 32'(bus1.oe), 32'd0);
        at_cyc(k + 4); chk("sw_ready4", 32'(bus1.req_ready), 32'd0);
        at_cyc(k + 5); chk("sw_ready5", 32'(bus1.req_ready), 32'd1);
        send(1, 1'b0, 4'h0, k);
        at_cyc(k + 2); chk("sw_rv2", 32'(bus1.rsp_valid), 32'd1); chk("sw_rd2", 32'(bus1.rsp_data), 32'hB);
        at_cyc(k + 3); chk("sw_rv3", 32'(bus1.rsp_valid), 32'd0);
        send(1, 1'b1, 4'h1, k);
        send(1, 1'b1, 4'h2, k2);
        chk("sw_period", 32'(k2), 32'(k + 5));

        // Randomized traffic.
        repeat (1500) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_data  = 4'($urandom_range(0, 15));
            din       = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        req_valid = 1'b0;

        // Reset while driving: oe must drop without a clock edge.
        send(0, 1'b1, 4'hE, k);
        at_cyc(k + 1); chk("mid_oe", 32'(bus0.oe), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_oe", 32'(bus0.oe), 32'd0);
        chk("async_dout", 32'(bus0.dout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_ready", 32'(bus0.req_ready), 32'd1);
        chk("post_rv", 32'(bus0.rsp_valid), 32'd0);
        chk("post_rd", 32'(bus0.rsp_data), 32'd0);
        chk("post_dout", 32'(bus0.dout), 32'd0);
        chk("post_busy", 32'(bus0.busy), 32'd0);
        repeat (8) @(negedge clk);

        chk("contention", 32'(contention), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
Initiator-side sequencer for a half-duplex shared bidirectional data bus. Accepts single-word read/write requests over a valid/ready handshake and drives the pin-level controls: output enable, outgoing data, and sampling of incoming data. Guarantees a programmable drive window and a programmable turnaround gap, so initiator and responder never drive the bus together. Sits between the host logic and the 4-bit bidirectional pin cell, which remains a separate instance at the pad boundary.

Parameters:
WIDTH, 4, bus data width in bits.
HOLD_CYCLES, 2, cycles the bus is driven (oe=1) per write; must be >=1.
SAMPLE_DELAY, 2, cycles the bus is released before read data is captured; must be >=1.
TURN_CYCLES, 1, bus-idle gap (oe=0) after every transaction; must be >=1.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst_n  input  1  reset, asynchronous and active-low.
req_valid  input  1  host request present.
req_ready  output  1  controller can accept a request this cycle.
req_write  input  1  1 = write, 0 = read; qualified by req_valid.
req_data  input  WIDTH  write data; qualified by req_valid & req_write.
rsp_valid  output  1  one-cycle pulse; rsp_data holds captured read data.
rsp_data  output  WIDTH  last captured read word.
busy  output  1  high whenever state != IDLE.
oe  output  1  output enable to the pin cell.
dout  output  WIDTH  data to the pin cell.
din  input  WIDTH  data from the pin cell (resolved bus value).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, oe=0, dout=0, rsp_valid=0, rsp_data=0, busy=0, counter=0. oe must drop in the same instant rst_n falls, with no clock needed. A transaction in flight is abandoned and produces no response.
- req_ready = (state==IDLE); it is combinational from registered state only.
- The handshake occurs on an edge where req_valid & req_ready are both high. req_write and req_data are latched at that edge. When req_valid is low, req_write and req_data are ignored.
- States: IDLE, WRITE, READ, TURN.
  - IDLE: on write accept go to WRITE; on read accept go to READ.
  - WRITE: oe=1, dout=latched data for exactly HOLD_CYCLES cycles, then go to TURN.
  - READ: oe=0 for exactly SAMPLE_DELAY cycles. On the edge ending the last READ cycle, din is registered into rsp_data; then go to TURN.
  - TURN: oe=0, dout=0 for exactly TURN_CYCLES cycles, then go to IDLE.
- rsp_valid is high only during the first TURN cycle that follows a READ. There is no backpressure on the response. rsp_data holds its value until the next read capture.
- oe=1 only in WRITE. dout=0 whenever oe=0, which keeps the bus deterministic for checking.
- Write timeline: accept at edge k; oe=1 on cycles k+1 .. k+HOLD_CYCLES. Next accept possible at edge k+1+HOLD_CYCLES+TURN_CYCLES.
- Read timeline: accept at edge k; capture at edge k+SAMPLE_DELAY; rsp_valid high in cycle k+SAMPLE_DELAY+1. Next accept possible at edge k+1+SAMPLE_DELAY+TURN_CYCLES.
- Write-to-read and read-to-write transitions both pass through TURN, so there is no direct WRITE->READ path.
- Counter: one down-counter, width $clog2(max(HOLD_CYCLES, SAMPLE_DELAY, TURN_CYCLES)+1). It is loaded with (N-1) on state entry and the state exits when it reaches 0.
- No combinational path from din to any output. oe, dout, rsp_* and busy are all registered or decoded from registered state.

Decomposition:
- Package bidir_bus_pkg holds:
  - the state enum (IDLE, WRITE, READ, TURN);
  - localparam DEFAULT_WIDTH=4;
  - a function computing the counter width from the three timing parameters.
- No sub-module inside the controller.
- Top-level wrapper bidir_bus_port instantiates bidir_bus_ctrl with the 4-bit bidirectional pin cell and connects oe/dout/din to the pin cell's OE/Dout/Din.

Test Plan:
- Reset: assert rst_n=0 mid-WRITE (oe=1) -> oe=0 immediately, no clock edge needed. After release: req_ready=1, rsp_valid=0, rsp_data=0, dout=0.
- Write (defaults): accept req_data=4'hA at edge k -> oe=1, dout=4'hA during cycles k+1..k+2; oe=0, dout=0 during cycle k+3; req_ready=1 at cycle k+4.
- Read (defaults): responder drives din=4'h5 from cycle k+1; accept read at edge k -> oe=0 throughout; rsp_valid=1 with rsp_data=4'h5 in cycle k+3 only; req_ready=1 at cycle k+4.
- Back-to-back write then read, req_valid held high -> TURN cycle with oe=0 separates them. A bench contention monitor (oe=1 while the responder drives) reports zero violations.
- Stall: req_valid=1 while busy -> request is not accepted, the latched data is unchanged, and the request is accepted on the first cycle req_ready=1.
- Parameter sweep HOLD_CYCLES=1, SAMPLE_DELAY=1, TURN_CYCLES=3 -> write: oe high for 1 cycle, accept period 5 cycles. Read: rsp_valid in cycle k+2, accept period 5 cycles.
